// File: rtl/dff_reg.sv
// dff_reg: multi-function register with load, shift, increment, decrement,
// complement, synchronous clear/set and synchronous active-low reset.
module dff_reg #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set,
    input  logic             clr,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nq,
    output logic             cy,
    output logic             zero
);

    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_INC  = 3'b100;
    localparam logic [2:0] M_DEC  = 3'b101;
    localparam logic [2:0] M_CPL  = 3'b110;

    logic [WIDTH-1:0] q_nx;
    logic             cy_nx;
    logic [WIDTH:0]   inc;
    logic [WIDTH:0]   dec;

    // The extra top bit carries the wrap-around carry or borrow.
    assign inc = {1'b0, q} + (WIDTH+1)'(1);
    assign dec = {1'b0, q} - (WIDTH+1)'(1);

    always_comb begin
        q_nx  = q;
        cy_nx = cy;
        unique case (mode)
            M_LOAD: begin
                q_nx  = d;
                cy_nx = 1'b0;
            end
            // Shift forms written so that WIDTH=1 degenerates to q<=sin.
            M_SHL: begin
                q_nx  = (q << 1) | WIDTH'(sin);
                cy_nx = q[WIDTH-1];
            end
            M_SHR: begin
                q_nx  = (q >> 1) | (WIDTH'(sin) << (WIDTH-1));
                cy_nx = q[0];
            end
            M_INC: begin
                q_nx  = inc[WIDTH-1:0];
                cy_nx = inc[WIDTH];
            end
            M_DEC: begin
                q_nx  = dec[WIDTH-1:0];
                cy_nx = dec[WIDTH];
            end
            M_CPL: begin
                q_nx  = ~q;
                cy_nx = 1'b0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q  <= RESET_VALUE;
            cy <= 1'b0;
        end else if (clr) begin
            q  <= '0;
            cy <= 1'b0;
        end else if (set) begin
            q  <= '1;
            cy <= 1'b0;
        end else begin
            q  <= q_nx;
            cy <= cy_nx;
        end
    end

    assign nq   = ~q;
    assign zero = ~|q;

endmodule

// File: tb/tb_dff_reg.sv
// Randomized scoreboard bench for dff_reg at WIDTH=8 (reset 8'h5A) and
// WIDTH=1, checked against an arithmetic reference model.
module tb_dff_reg;

    typedef struct {
        longint q;
        bit     cy;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       rst8 = 1'b1, set8 = 1'b0, clr8 = 1'b0, sin8 = 1'b0;
    logic [2:0] mode8 = 3'b000;
    logic [7:0] d8 = 8'h00;
    logic [7:0] q8, nq8;
    logic       cy8, zero8;

    logic       rst1 = 1'b1, set1 = 1'b0, clr1 = 1'b0, sin1 = 1'b0;
    logic [2:0] mode1 = 3'b000;
    logic [0:0] d1 = 1'b0;
    logic [0:0] q1, nq1;
    logic       cy1, zero1;

    dff_reg #(.WIDTH(8), .RESET_VALUE(8'h5A)) u8 (
        .clk(clk), .rst_n(rst8), .set(set8), .clr(clr8), .mode(mode8),
        .d(d8), .sin(sin8), .q(q8), .nq(nq8), .cy(cy8), .zero(zero8)
    );

    dff_reg #(.WIDTH(1), .RESET_VALUE(1'b0)) u1 (
        .clk(clk), .rst_n(rst1), .set(set1), .clr(clr1), .mode(mode1),
        .d(d1), .sin(sin1), .q(q1), .nq(nq1), .cy(cy1), .zero(zero1)
    );

    exp_t sb8[$];
    exp_t sb1[$];
    longint m8 = 0, m1 = 0;
    bit     c8 = 0, c1 = 0;
    bit     done8 = 0, done1 = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the register as a number modulo 2^w.
    function automatic void ref_step(
        input int w, input longint rv, input bit rn, input bit st, input bit cl,
        input int md, input longint dv, input bit si,
        inout longint m, inout bit c
    );
        longint mask = (longint'(1) << w) - 1;
        if (!rn) begin m = rv; c = 0; end
        else if (cl) begin m = 0; c = 0; end
        else if (st) begin m = mask; c = 0; end
        else case (md)
            1: begin m = dv & mask; c = 0; end
            2: begin c = (m >> (w-1)) & 1; m = ((m * 2) + si) % (mask + 1); end
            3: begin c = m % 2; m = (m / 2) + (longint'(si) << (w-1)); end
            4: begin c = (m == mask); m = (m + 1) % (mask + 1); end
            5: begin c = (m == 0); m = (m + mask) % (mask + 1); end
            6: begin m = mask - m; c = 0; end
            default: ;
        endcase
    endfunction

    task automatic step8(input bit rn, st, cl, input int md, input int dv,
                         input bit si, input bit use_k = 0,
                         input int kq = 0, input bit kc = 0);
        exp_t e;
        @(negedge clk);
        rst8 = rn; set8 = st; clr8 = cl; mode8 = 3'(md);
        d8 = 8'(dv); sin8 = si;
        ref_step(8, 64'h5A, rn, st, cl, md, dv, si, m8, c8);
        e.q  = use_k ? longint'(kq) : m8;
        e.cy = use_k ? kc : c8;
        sb8.push_back(e);
    endtask

    task automatic step1(input bit rn, st, cl, input int md, input int dv,
                         input bit si, input bit use_k = 0,
                         input int kq = 0, input bit kc = 0);
        exp_t e;
        @(negedge clk);
        rst1 = rn; set1 = st; clr1 = cl; mode1 = 3'(md);
        d1 = 1'(dv); sin1 = si;
        ref_step(1, 0, rn, st, cl, md, dv, si, m1, c1);
        e.q  = use_k ? longint'(kq) : m1;
        e.cy = use_k ? kc : c1;
        sb1.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb8.size() > 0) begin
            e = sb8.pop_front();
            chk("q8", longint'(q8), e.q);
            chk("cy8", longint'(cy8), longint'(e.cy));
            chk("nq8", longint'(nq8), longint'(~e.q & 8'hFF));
            chk("zero8", longint'(zero8), longint'(e.q == 0));
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb1.size() > 0) begin
            e = sb1.pop_front();
            chk("q1", longint'(q1), e.q);
            chk("cy1", longint'(cy1), longint'(e.cy));
            chk("nq1", longint'(nq1), longint'(~e.q & 1));
            chk("zero1", longint'(zero1), longint'(e.q == 0));
        end
    end

    initial begin
        step8(0, 1, 0, 4, 0,    0, 1, 8'h5A, 0);
        step8(1, 0, 0, 1, 8'hFE, 0, 1, 8'hFE, 0);
        step8(1, 0, 0, 4, 0,    0, 1, 8'hFF, 0);
        step8(1, 0, 0, 4, 0,    0, 1, 8'h00, 1);
        step8(1, 0, 0, 5, 0,    0, 1, 8'hFF, 1);
        step8(1, 0, 0, 0, 8'h12, 1, 1, 8'hFF, 1);
        step8(1, 0, 0, 7, 8'h34, 1, 1, 8'hFF, 1);
        step8(1, 0, 0, 1, 8'h81, 0, 1, 8'h81, 0);
        step8(1, 0, 0, 2, 0,    0, 1, 8'h02, 1);
        step8(1, 0, 0, 3, 0,    1, 1, 8'h81, 0);
        step8(1, 0, 0, 6, 0,    0, 1, 8'h7E, 0);
        step8(1, 1, 1, 1, 8'h33, 0, 1, 8'h00, 0);
        step8(1, 1, 0, 1, 8'h33, 0, 1, 8'hFF, 0);
        step8(1, 0, 0, 4, 0,    0, 1, 8'h00, 1);
        step8(0, 0, 0, 4, 0,    0, 1, 8'h5A, 0);
        step8(1, 0, 0, 4, 0,    0, 1, 8'h5B, 0);
        for (int i = 0; i < 400; i++)
            step8($urandom_range(15) != 0, $urandom_range(7) == 0,
                  $urandom_range(7) == 0, int'($urandom_range(7)),
                  int'($urandom_range(255)), 1'($urandom));
        done8 = 1;
    end

    initial begin
        step1(0, 1, 0, 4, 1, 1, 1, 0, 0);
        step1(1, 1, 0, 0, 0, 0, 1, 1, 0);
        step1(1, 0, 0, 2, 0, 0, 1, 0, 1);
        step1(1, 0, 0, 4, 0, 0, 1, 1, 0);
        step1(1, 0, 0, 4, 0, 0, 1, 0, 1);
        step1(1, 0, 0, 3, 0, 1, 1, 1, 0);
        step1(1, 0, 0, 5, 0, 0, 1, 0, 0);
        step1(1, 0, 0, 5, 0, 0, 1, 1, 1);
        for (int i = 0; i < 300; i++)
            step1($urandom_range(15) != 0, $urandom_range(7) == 0,
                  $urandom_range(7) == 0, int'($urandom_range(7)),
                  int'($urandom_range(1)), 1'($urandom));
        done1 = 1;
    end

    initial begin
        int n = 0;
        while (!(done8 && done1) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (!(done8 && done1)) begin
            errors++;
            $display("FAIL timeout: done8=%0d done1=%0d expected 1 1", done8, done1);
        end
        repeat (3) @(posedge clk);
        #2;
        chk("drain8", longint'(sb8.size()), 0);
        chk("drain1", longint'(sb1.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dff_reg.md
DFF_REG -- requirements
Module: dff_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits (1..32).
REQ-002 SHALL have parameter RESET_VALUE, default 0, WIDTH-bit value loaded by reset.
REQ-003 SHALL have port clk  input  1  sole clock, all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port set  input  1  synchronous set-all request, active-high.
REQ-006 SHALL have port clr  input  1  synchronous clear-all request, active-high.
REQ-007 SHALL have port mode  input  3  operation select (see REQ-012).
REQ-008 SHALL have port d  input  WIDTH  parallel load data.
REQ-009 SHALL have port sin  input  1  serial input bit for shift modes.
REQ-010 SHALL have port q, nq, cy, zero, as follows: q  output  WIDTH  register state; nq  output  WIDTH  bitwise complement of q; cy  output  1  registered carry/borrow/shift-out; zero  output  1  high when q is all zeros.

Function
REQ-011 SHALL apply per-edge priority: rst_n low > clr > set > mode.
REQ-012 SHALL decode mode as follows: 000 hold; 001 load q<=d; 010 shift left q<={q[W-2:0],sin}; 011 shift right q<={sin,q[W-1:1]}; 100 increment q<=q+1; 101 decrement q<=q-1; 110 complement q<=~q; 111 hold.
REQ-013 SHALL, in shift left, load cy with the departing q[W-1]; in shift right, load cy with the departing q[0].
REQ-014 SHALL, in increment, wrap all-ones to zero and set cy=1; otherwise cy=0.
REQ-015 SHALL, in decrement, wrap zero to all-ones and set cy=1 (borrow); otherwise cy=0.
REQ-016 SHALL leave cy unchanged in hold (000, 111), and clear cy to 0 in load and complement.
REQ-017 SHALL, on clr, force q to 0 and cy to 0; on set (clr low), force q to all-ones and cy to 0.
REQ-018 SHALL, for WIDTH=1, treat shifts as q<=sin with cy taking the old q.
REQ-019 SHALL drive nq as exactly ~q at all times, with no cycle of skew.
REQ-020 SHALL drive zero combinationally from q, with no registered lag.
REQ-021 SHALL have a latency of one clock edge for all operations; results are visible on q after the edge that samples them.
REQ-022 SHALL perform arithmetic modulo 2^WIDTH with no saturation.

Reset
REQ-023 SHALL, on a rising clk with rst_n low, load q<=RESET_VALUE and cy<=0, regardless of set, clr, or mode.
REQ-024 SHALL leave q and cy unchanged by rst_n when no clock edge occurs; there is no asynchronous effect.
REQ-025 SHALL, when reset is asserted mid-sequence (e.g. during a run of increments), discard the operation on that edge; operation resumes from RESET_VALUE on the first edge after rst_n returns high.

Verification
REQ-026 The bench SHALL cover reset with WIDTH=8, RESET_VALUE=8'h5A: hold rst_n low for 1 edge with mode=100 and set=1 -> q=8'h5A, nq=8'hA5, cy=0, zero=0.
REQ-027 The bench SHALL cover load/increment wrap: load d=8'hFE, then apply 2 increments -> q=8'hFF with cy=0, then q=8'h00 with cy=1 and zero=1.
REQ-028 The bench SHALL cover decrement borrow: from q=8'h00, apply mode=101 -> q=8'hFF, cy=1; then apply mode=000 -> q and cy unchanged.
REQ-029 The bench SHALL cover shifts: q=8'h81 with sin=0 under shift left -> q=8'h02, cy=1; then sin=1 under shift right -> q=8'h81, cy=0.
REQ-030 The bench SHALL cover priority: set=1 with clr=1 and mode=001 (d=8'h33) -> q=8'h00; then set=1 alone -> q=8'hFF, cy=0.
REQ-031 The bench SHALL cover WIDTH=1: with q=1 and sin=0, apply shift left -> q=0, cy=1; then apply increment -> q=1, cy=0; then apply increment -> q=0, cy=1.
